pdm_clk_sequencer: RTL and testbench

- Runtime controller and generator for the PDM microphone clock M_CLK.
- Sequences mic power-up: idle clock held low, then a wake/settle interval, then run with data_valid.
- Applies divider changes glitch-free, only at a falling boundary, and drains to a clean low level on disable.
- Sits between the control/register interface and the PDM capture/decimation chain, which consumes M_CLK, the strobes and data_valid.

---
 rtl/pdm_clk_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pdm_clk_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_clk_sequencer.sv
// PDM microphone clock generator and power-up sequencer: IDLE -> WAKE (settle) -> RUN, glitch-free divider changes.
// Define PDM_CLK_FALLING_EN to add the m_clk_falling strobe output.

module pdm_clk_sequencer #(
  parameter int unsigned DIV_W            = 8,
  parameter int unsigned HALF_DIV_DEFAULT = 25,
  parameter int unsigned WAKE_CYCLES      = 32768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] half_div,
  input  logic             cfg_update,
  output logic             M_CLK,
  output logic             m_clk_rising,
  output logic             data_valid,
  output logic             busy,
  output logic [1:0]       state
`ifdef PDM_CLK_FALLING_EN
  ,
  output logic             m_clk_falling
`endif
);

  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAKE  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              mclk_q, mclk_d;
  logic              rise_q, rise_d;
  logic              dv_q, dv_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  pdiv_q, pdiv_d;
  logic [DIV_W-1:0]  phase_q, phase_d;
  logic [DIV_W-1:0]  div_eff;
  logic [WAKE_W-1:0] wake_q, wake_d;
  logic              tc;
  logic              fall_tc;
`ifdef PDM_CLK_FALLING_EN
  logic              fall_q, fall_d;
`endif

  // A zero divider behaves as 1: M_CLK = clk/2.
  assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
  assign tc      = (phase_q == div_eff - DIV_W'(1));
  assign fall_tc = tc && mclk_q;

  always_comb begin
    state_d = state_q;
    mclk_d  = mclk_q;
    rise_d  = 1'b0;
    dv_d    = dv_q;
    pend_d  = pend_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    phase_d = phase_q;
    wake_d  = wake_q;
`ifdef PDM_CLK_FALLING_EN
    fall_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        mclk_d  = 1'b0;
        dv_d    = 1'b0;
        phase_d = '0;
        wake_d  = '0;
        if (pend_q) begin
          div_d  = pdiv_q;
          pend_d = 1'b0;
        end
        if (enable) state_d = WAKE;
      end

      WAKE, RUN: begin
        if (tc) begin
          phase_d = '0;
          mclk_d  = !mclk_q;
          rise_d  = !mclk_q;
`ifdef PDM_CLK_FALLING_EN
          fall_d  = mclk_q;
`endif
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end

        if (state_q == WAKE && rise_q) begin
          wake_d = wake_q + WAKE_W'(1);
          if (wake_q == WAKE_W'(WAKE_CYCLES - 1)) begin
            state_d = RUN;
            dv_d    = 1'b1;
          end
        end

        // New divisor takes over at the falling toggle; the mic must re-settle.
        if (fall_tc && pend_q) begin
          div_d   = pdiv_q;
          pend_d  = 1'b0;
          wake_d  = '0;
          state_d = WAKE;
          dv_d    = 1'b0;
        end

        if (!enable) begin
          state_d = DRAIN;
          dv_d    = 1'b0;
        end
      end

      DRAIN: begin
        dv_d = 1'b0;
        if (!mclk_q) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (tc) begin
          phase_d = '0;
          mclk_d  = 1'b0;
          state_d = IDLE;
`ifdef PDM_CLK_FALLING_EN
          fall_d  = 1'b1;
`endif
          if (pend_q) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
          end
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
    endcase

    // Capture last so a same-cycle pulse waits for the next apply point.
    if (cfg_update) begin
      pdiv_d = half_div;
      pend_d = 1'b1;
    end

    busy_d = (state_d != IDLE) || pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mclk_q  <= 1'b0;
      rise_q  <= 1'b0;
      dv_q    <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      div_q   <= DIV_W'(HALF_DIV_DEFAULT);
      pdiv_q  <= DIV_W'(HALF_DIV_DEFAULT);
      phase_q <= '0;
      wake_q  <= '0;
`ifdef PDM_CLK_FALLING_EN
      fall_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mclk_q  <= mclk_d;
      rise_q  <= rise_d;
      dv_q    <= dv_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      phase_q <= phase_d;
      wake_q  <= wake_d;
`ifdef PDM_CLK_FALLING_EN
      fall_q  <= fall_d;
`endif
    end
  end

  assign M_CLK        = mclk_q;
  assign m_clk_rising = rise_q;
  assign data_valid   = dv_q;
  assign busy         = busy_q;
  assign state        = state_q;
`ifdef PDM_CLK_FALLING_EN
  assign m_clk_falling = fall_q;
`endif

endmodule

// File: tb/tb_pdm_clk_sequencer.sv
// Scoreboard bench for pdm_clk_sequencer: an edge-deadline reference model predicts every output change,
// a monitor compares each observed change; directed checks cover the timing rules.
module tb_pdm_clk_sequencer;
  localparam int unsigned DIV_W = 8;
  localparam int HDEF = 25;
  localparam int WAKE = 4;
`ifdef PDM_CLK_FALLING_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif
  localparam int EV_R = 0, EV_F = 1, EV_U = 2, EV_D = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic cfg_update = 1'b0;
  logic [DIV_W-1:0] half_div = '0;
  logic M_CLK, m_clk_rising, data_valid, busy;
  logic [1:0] state;
  logic m_clk_falling;

  pdm_clk_sequencer #(
    .DIV_W(DIV_W),
    .HALF_DIV_DEFAULT(HDEF),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .half_div(half_div),
    .cfg_update(cfg_update),
    .M_CLK(M_CLK),
    .m_clk_rising(m_clk_rising),
    .data_valid(data_valid),
    .busy(busy),
    .state(state)
`ifdef PDM_CLK_FALLING_EN
    ,
    .m_clk_falling(m_clk_falling)
`endif
  );
`ifndef PDM_CLK_FALLING_EN
  assign m_clk_falling = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       mclk;
    logic       rise;
    logic       fall;
    logic       dv;
    logic [1:0] st;
    logic       busy;
  } obs_t;
  typedef struct { int c; obs_t o; } rec_t;
  typedef struct { int c; int k; } ev_t;

  rec_t exp_q[$];
  ev_t  ev_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.mclk = M_CLK;
    o.rise = m_clk_rising;
    o.fall = m_clk_falling;
    o.dv   = data_valid;
    o.st   = state;
    o.busy = busy;
    return o;
  endfunction

  task automatic chk_rst(input string name);
    obs_t o;
    o = dut_obs();
    n_chk++;
    if (o === obs_t'(0)) n_pass++;
    else $display("FAIL %s: got outputs %b, expected %b", name, o, obs_t'(0));
  endtask

  // Reference model: tracks the absolute edge at which M_CLK next toggles.
  int m_st, m_div, m_pdiv, m_rises, m_due, m_edge;
  bit m_mclk, m_rise, m_fall, m_dv, m_pend;
  obs_t m_last = '0;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.mclk = m_mclk;
    o.rise = m_rise;
    o.fall = FALL_EN ? m_fall : 1'b0;
    o.dv   = m_dv;
    o.st   = 2'(m_st);
    o.busy = (m_st != 0) || m_pend;
    return o;
  endfunction

  task automatic model_step(input bit r, input bit en, input bit cu, input int hd);
    int e, st_n, div_n, pdiv_n, rises_n, due_n;
    bit tog, mclk_n, rise_n, fall_n, dv_n, pend_n;
    obs_t o;
    e = cyc + 1;
    if (r) begin
      m_st = 0; m_div = HDEF; m_pdiv = HDEF; m_pend = 0; m_rises = 0; m_due = 0;
      m_mclk = 0; m_rise = 0; m_fall = 0; m_dv = 0;
    end else begin
      st_n = m_st; div_n = m_div; pdiv_n = m_pdiv; rises_n = m_rises; due_n = m_due;
      mclk_n = m_mclk; dv_n = m_dv; pend_n = m_pend; rise_n = 0; fall_n = 0;
      tog = (e == m_due);
      case (m_st)
        0: begin
          mclk_n = 0; dv_n = 0; rises_n = 0;
          if (m_pend) begin div_n = m_pdiv; pend_n = 0; end
          if (en) begin st_n = 1; due_n = e + eff(div_n); end
        end
        1, 2: begin
          if (m_st == 1 && m_rise) begin
            rises_n = m_rises + 1;
            if (rises_n == WAKE) begin st_n = 2; dv_n = 1; end
          end
          if (tog) begin mclk_n = !m_mclk; rise_n = !m_mclk; fall_n = m_mclk; end
          if (tog && m_mclk && m_pend) begin
            div_n = m_pdiv; pend_n = 0; rises_n = 0; st_n = 1; dv_n = 0;
          end
          if (tog) due_n = e + eff(div_n);
          if (!en) begin st_n = 3; dv_n = 0; end
        end
        default: begin
          dv_n = 0;
          if (!m_mclk) st_n = 0;
          else if (tog) begin
            mclk_n = 0; fall_n = 1; st_n = 0;
            if (m_pend) begin div_n = m_pdiv; pend_n = 0; end
          end
        end
      endcase
      if (cu) begin pdiv_n = hd; pend_n = 1; end
      m_st = st_n; m_div = div_n; m_pdiv = pdiv_n; m_rises = rises_n; m_due = due_n;
      m_mclk = mclk_n; m_rise = rise_n; m_fall = fall_n; m_dv = dv_n; m_pend = pend_n;
    end
    m_edge = e;
    o = model_obs();
    if (o != m_last) begin
      exp_q.push_back('{c: e, o: o});
      m_last = o;
    end
  endtask

  task automatic drive(input bit r, input bit en, input bit cu, input int hd);
    @(negedge clk);
    rst = r;
    enable = en;
    cfg_update = cu;
    half_div = DIV_W'(hd);
    model_step(r, en, cu, hd);
  endtask

  task automatic run_until_rise(input bit en, output int r);
    r = -1;
    for (int i = 0; i < 2000; i++) begin
      drive(0, en, 0, 0);
      if (m_rise) begin
        r = m_edge;
        return;
      end
    end
    n_chk++;
    $display("FAIL timeout_rise: no rising strobe within 2000 cycles");
  endtask

  task automatic run_until_run();
    for (int i = 0; i < 2000; i++) begin
      if (m_st == 2) return;
      drive(0, 1, 0, 0);
    end
    n_chk++;
    $display("FAIL timeout_run: RUN not reached within 2000 cycles");
  endtask

  function automatic int ev_find(input int k, input int after, input int nth);
    int n;
    n = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].k == k && ev_q[i].c > after) begin
        n++;
        if (n == nth) return ev_q[i].c;
      end
    end
    return -1;
  endfunction

  // Monitor: every change of the output vector must match the next predicted change.
  initial begin
    obs_t prev, cur;
    rec_t rc;
    wait (mon_on);
    prev = '0;
    forever begin
      @(negedge clk);
      cur = dut_obs();
      if (cur !== prev) begin
        if (cur.rise && !prev.rise) ev_q.push_back('{c: cyc, k: EV_R});
        if (!cur.mclk && prev.mclk) ev_q.push_back('{c: cyc, k: EV_F});
        if (cur.dv && !prev.dv)     ev_q.push_back('{c: cyc, k: EV_U});
        if (!cur.dv && prev.dv)     ev_q.push_back('{c: cyc, k: EV_D});
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: cycle %0d outputs %b, no change expected", cyc, cur);
        end else begin
          rc = exp_q.pop_front();
          if (rc.c == cyc && rc.o === cur) n_pass++;
          else $display("FAIL sb_change: got cycle %0d outputs %b, expected cycle %0d outputs %b",
                        cyc, cur, rc.c, rc.o);
        end
        prev = cur;
      end
    end
  end

  initial begin
    int w, r, u, s, f0, a1, a2, a3, a4, r1, r2, r3, r4;
    bit en_r;

    repeat (3) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk_rst("reset_out");
    mon_on = 1'b1;

    // Power-up with default divider.
    drive(0, 1, 0, 0);
    w = m_edge;
    repeat (240) drive(0, 1, 0, 0);
    r1 = ev_find(EV_R, w, 1); r2 = ev_find(EV_R, w, 2);
    r3 = ev_find(EV_R, w, 3); r4 = ev_find(EV_R, w, 4);
    chk("t1_first_rise", r1 - w, 25);
    chk("t1_period", r2 - r1, 50);
    chk("t1_period_b", r4 - r3, 50);
    chk("t1_dv_after_4th", ev_find(EV_U, w, 1) - r4, 1);
    chk("t1_state_run", int'(state), 2);

    // Divider update mid-high-phase in RUN.
    run_until_rise(1, r);
    repeat (4) drive(0, 1, 0, 0);
    drive(0, 1, 1, 10);
    u = m_edge;
    repeat (160) drive(0, 1, 0, 0);
    f0 = ev_find(EV_F, u, 1);
    a1 = ev_find(EV_R, f0, 1); a2 = ev_find(EV_R, f0, 2);
    a3 = ev_find(EV_R, f0, 3); a4 = ev_find(EV_R, f0, 4);
    chk("t2_high_kept", f0 - r, 25);
    chk("t2_low_new", a1 - f0, 10);
    chk("t2_dv_drop", ev_find(EV_D, u, 1), f0);
    chk("t2_period", a2 - a1, 20);
    chk("t2_period_b", a4 - a3, 20);
    chk("t2_dv_back", ev_find(EV_U, f0, 1) - a4, 1);

    // Disable with 5 clks of the high phase left.
    run_until_rise(1, r);
    repeat (5) drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    s = m_edge;
    repeat (30) drive(0, 0, 0, 0);
    chk("t3_dv_drop", ev_find(EV_D, s - 1, 1), s);
    chk("t3_fall", ev_find(EV_F, s - 1, 1) - s, 4);
    chk("t3_no_rise", ev_find(EV_R, s, 1), -1);
    chk("t3_idle", int'(state), 0);
    chk("t3_mclk_low", int'(M_CLK), 0);

    // Zero divider programmed in IDLE.
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    w = m_edge;
    repeat (20) drive(0, 1, 0, 0);
    r1 = ev_find(EV_R, w, 1); r2 = ev_find(EV_R, w, 2);
    chk("t4_first_rise", r1 - w, 1);
    chk("t4_period", r2 - r1, 2);
    chk("t4_period_b", ev_find(EV_R, w, 6) - ev_find(EV_R, w, 5), 2);

    // Reset in RUN with an update pending.
    run_until_run();
    drive(0, 1, 1, 7);
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk_rst("t5_reset_out");
    drive(0, 1, 0, 0);
    w = m_edge;
    repeat (120) drive(0, 1, 0, 0);
    r1 = ev_find(EV_R, w, 1); r2 = ev_find(EV_R, w, 2);
    chk("t5_default_first", r1 - w, 25);
    chk("t5_default_period", r2 - r1, 50);

    // Randomized traffic against the model.
    en_r = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      bit r_b, cu_b;
      int hd_v;
      r_b  = ($urandom_range(0, 2999) == 0);
      cu_b = ($urandom_range(0, 39) == 0);
      hd_v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 14));
      if ($urandom_range(0, 199) == 0) en_r = !en_r;
      drive(r_b, en_r, cu_b, hd_v);
    end
    repeat (40) drive(0, 0, 0, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
